// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter:
// state encoding and the default watchdog counter width.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int WDOG_WIDTH = 8;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter: counts strobed cycles without a slave response
// and raises expire once the count reaches the limit, until the owner is released.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int width = WDOG_WIDTH,
  parameter int limit = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  input  logic armed,
  output logic expire
);

  localparam logic [width-1:0] limit_cnt = width'(limit);

  logic [width-1:0] cnt;

  // Saturates at the limit so expire stays stable until the FSM leaves the grant.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (run && (cnt != limit_cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = armed && (cnt == limit_cnt);

endmodule

// File: rtl/wb_arb2_rr.sv
// Two-master, one-slave Wishbone round-robin arbiter; grant held for the whole cyc.
// Optional stall watchdog enabled by defining WB_ARB2_TIMEOUT_EN.
module wb_arb2_rr
  import wb_arb_pkg::*;
#(
  parameter int adr_width = 32,
  parameter int dat_width = 32,
  parameter int timeout   = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [adr_width-1:0]   m0_adr_i,
  input  logic [adr_width-1:0]   m1_adr_i,
  input  logic [dat_width-1:0]   m0_dat_i,
  input  logic [dat_width-1:0]   m1_dat_i,
  output logic [dat_width-1:0]   m0_dat_o,
  output logic [dat_width-1:0]   m1_dat_o,
  input  logic [dat_width/8-1:0] m0_sel_i,
  input  logic [dat_width/8-1:0] m1_sel_i,
  input  logic                   m0_we_i,
  input  logic                   m1_we_i,
  input  logic                   m0_cyc_i,
  input  logic                   m1_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m1_stb_i,
  output logic                   m0_ack_o,
  output logic                   m1_ack_o,
  output logic                   m0_err_o,
  output logic                   m1_err_o,
  output logic [adr_width-1:0]   s_adr_o,
  output logic [dat_width-1:0]   s_dat_o,
  input  logic [dat_width-1:0]   s_dat_i,
  output logic [dat_width/8-1:0] s_sel_o,
  output logic                   s_we_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [1:0]             gnt_o
);

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic       expire;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Owners always pass through IDLE, which leaves one dead cycle between them.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i || expire) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i || expire) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    s_we_o   = m0_we_i;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    case (state)
      GNT0: begin
        gnt_o    = 2'b01;
        s_cyc_o  = m0_cyc_i & ~expire;
        s_stb_o  = m0_stb_i & ~expire;
        m0_ack_o = s_ack_i & ~expire;
        m0_err_o = s_err_i | expire;
      end
      GNT1: begin
        gnt_o    = 2'b10;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i & ~expire;
        s_stb_o  = m1_stb_i & ~expire;
        m1_ack_o = s_ack_i & ~expire;
        m1_err_o = s_err_i | expire;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef WB_ARB2_TIMEOUT_EN
  logic wd_run;
  logic wd_clear;

  assign wd_run   = ((state == GNT0) && m0_stb_i) || ((state == GNT1) && m1_stb_i);
  assign wd_clear = (state == IDLE) || s_ack_i || s_err_i;

  wb_arb_watchdog #(
    .width (WDOG_WIDTH),
    .limit (timeout)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .run     (wd_run),
    .armed   (state != IDLE),
    .expire  (expire)
  );
`else
  assign expire = 1'b0;
`endif

endmodule

// File: doc/wb_arb2_rr.md
Name:
wb_arb2_rr

Overview:
Two-master, one-slave Wishbone round-robin arbiter. Shares a single slave (SRAM controller or BRAM) between the LM32 instruction and data buses, so both masters can run from external SRAM without the full crossbar. Grant is held for the whole cycle (cyc_i high), so it follows LM32 incrementing bursts. Sits between the lm32 bus ports and wb_sram32 / wb_bram.

Parameters:
adr_width, 32, address width on master and slave sides
dat_width, 32, data width (sel width = dat_width/8)
timeout, 255, watchdog limit in cycles (used only with WB_ARB2_TIMEOUT_EN; 8-bit counter, legal range 1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
m0_adr_i / m1_adr_i  in  adr_width  master address
m0_dat_i / m1_dat_i  in  dat_width  master write data
m0_dat_o / m1_dat_o  out  dat_width  read data; both driven from s_dat_i
m0_sel_i / m1_sel_i  in  dat_width/8  byte selects
m0_we_i / m1_we_i  in  1  write enable
m0_cyc_i / m1_cyc_i  in  1  cycle request
m0_stb_i / m1_stb_i  in  1  strobe
m0_ack_o / m1_ack_o  out  1  acknowledge, granted master only
m0_err_o / m1_err_o  out  1  error, granted master only
s_adr_o  out  adr_width  muxed address
s_dat_o  out  dat_width  muxed write data
s_dat_i  in  dat_width  slave read data
s_sel_o  out  dat_width/8  muxed byte selects
s_we_o  out  1  muxed write enable
s_cyc_o  out  1  cyc of granted master, 0 when idle
s_stb_o  out  1  stb of granted master, 0 when idle
s_ack_i  in  1  slave acknowledge
s_err_i  in  1  slave error
gnt_o  out  2  one-hot grant {m1,m0}; 2'b00 when idle (debug/LAC probe)

Behaviour:
- FSM states: IDLE, GNT0, GNT1. The state register and last-served bit (last) are the only sequential state apart from the watchdog.
- Reset (reset_n=0 at a clk edge): state=IDLE, last=1, so m0 wins the first tie.
- Reset outputs: s_cyc_o=s_stb_o=0, all ack/err=0, gnt_o=00. s_adr_o/s_dat_o/s_sel_o/s_we_o follow m0 (don't-care while s_cyc_o=0).
- IDLE transitions:
  - only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1.
  - both high -> grant the master != last.
  - The grant registers on the edge, so the first s_stb_o appears one cycle after the request (1-cycle arbitration latency).
- GNTx: all slave outputs combinationally muxed from master x. s_ack_i/s_err_i routed to mx only; the other master sees ack=err=0.
- GNTx -> IDLE when mx_cyc_i=0; last<=x. No direct GNT0->GNT1 hop, so there is always one idle cycle between owners.
- A master that drops cyc mid-burst is released the same way; in-flight slave ack in that cycle is dropped (slave must tolerate it).
- Fairness: with both masters continuously re-requesting, grants strictly alternate 0,1,0,1...
- Reset asserted mid-transfer: next state IDLE, s_cyc_o=0 from the following cycle, no ack forwarded after reset.
- Any ack/err arriving in IDLE is ignored.

Optional Feature:
WB_ARB2_TIMEOUT_EN
- Defined:
  - 8-bit watchdog cleared on every grant and on each s_ack_i/s_err_i; increments while s_stb_o=1 without response.
  - When it reaches timeout: assert mx_err_o for exactly one cycle, force s_cyc_o=s_stb_o=0 that cycle, go to IDLE, last<=x.
- Not defined: no counter; err_o is a pure passthrough of s_err_i, and a hung slave hangs the owning master indefinitely.

Decomposition:
- Shared package wb_arb_pkg: state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and default watchdog width 8.
- Natural sub-module: wb_arb_watchdog (counter + expiry pulse), instantiated only under WB_ARB2_TIMEOUT_EN.
- Mux and FSM stay in the top.

Test Plan:
- Reset release, m0 reads 0x40000010, slave acks on 2nd stb cycle -> gnt_o=01 one cycle after cyc; m0_ack_o=1 for one cycle with m0_dat_o=s_dat_i; m1_ack_o=0 throughout.
- m0 and m1 raise cyc on the same cycle from reset -> m0 granted first; after m0 drops cyc, one IDLE cycle, then gnt_o=10.
- Both masters issue 4 back-to-back single cycles each -> grant order 0,1,0,1,0,1,0,1; no ack ever on the non-granted master.
- m1 4-beat burst (cyc held, 4 acks) while m0 requests mid-burst -> m1 keeps grant for all 4 beats; m0 granted only after m1 cyc falls.
- reset_n pulled low during an m0 write with stb high -> next cycle s_cyc_o=0, gnt_o=00, no ack to m0; after release, normal arbitration resumes.
- (TIMEOUT_EN, timeout=8) slave never acks m0 -> m0_err_o pulses once, 8 cycles after first stb; arbiter returns to IDLE; pending m1 granted next.
